// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PCTRL_RUN    = 2'd0,
    PCTRL_MCWAIT = 2'd1,
    PCTRL_TRAP   = 2'd2
  } pctrl_state_e;

  typedef enum logic [1:0] {
    PC_SEL_SEQ   = 2'b00,
    PC_SEL_REDIR = 2'b01,
    PC_SEL_TRAP  = 2'b10
  } pc_sel_e;

  localparam int unsigned B_IFID  = 0;
  localparam int unsigned B_IDEX  = 1;
  localparam int unsigned B_EXMEM = 2;
  localparam int unsigned B_MEMWB = 3;

  function automatic logic [3:0] bmask(input int unsigned b);
    return 4'(1 << b);
  endfunction

  localparam logic [3:0] M_NONE  = '0;
  localparam logic [3:0] M_ALL   = '1;
  localparam logic [3:0] M_IDEX  = bmask(B_IDEX);
  localparam logic [3:0] M_MEMWB = bmask(B_MEMWB);
  localparam logic [3:0] M_FRONT = bmask(B_IFID) | bmask(B_IDEX);
  localparam logic [3:0] M_BACK  = bmask(B_EXMEM) | bmask(B_MEMWB);

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipeline-register controls of the stall/flush sequencer.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             i_load_use;
  logic             i_redirect;
  logic             i_mc_start;
  logic             i_mc_done;
  logic             i_lsu_stall;
  logic             i_lsu_busy;
  logic             i_trap;
  logic [3:0]       o_en;
  logic [3:0]       o_flush;
  logic             o_pc_en;
  logic [1:0]       o_pc_sel;
  logic             o_mc_go;
  logic             o_mc_kill;
  logic [CNT_W-1:0] o_stall_cnt;

  // master: the sequencer; slave: the pipeline it controls
  modport master (
    input  i_load_use, i_redirect, i_mc_start, i_mc_done,
           i_lsu_stall, i_lsu_busy, i_trap,
    output o_en, o_flush, o_pc_en, o_pc_sel, o_mc_go, o_mc_kill, o_stall_cnt
  );

  modport slave (
    output i_load_use, i_redirect, i_mc_start, i_mc_done,
           i_lsu_stall, i_lsu_busy, i_trap,
    input  o_en, o_flush, o_pc_en, o_pc_sel, o_mc_go, o_mc_kill, o_stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous active-high clear.
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != '1)) begin
      o_cnt <= o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: fixed-priority hazard resolution, trap drain
// and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  pipe_ctrl_if.master bus
);

  localparam int DW = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);
  localparam logic [DW-1:0] DRAIN_MAX = DW'(FLUSH_CYC);

  pctrl_state_e  state, state_n;
  logic [DW-1:0] drain;
  logic          drain_clr;
  logic [3:0]    en, flush;
  logic          pc_en;
  pc_sel_e       pc_sel;
  logic          mc_go, mc_kill;
  logic          stall_inc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= PCTRL_RUN;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || drain_clr) begin
      drain <= '0;
    end else if ((state == PCTRL_TRAP) && (drain != DRAIN_MAX)) begin
      drain <= drain + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    drain_clr = 1'b0;
    en        = M_NONE;
    flush     = M_NONE;
    pc_en     = 1'b0;
    pc_sel    = PC_SEL_SEQ;
    mc_go     = 1'b0;
    mc_kill   = 1'b0;

    unique case (state)
      PCTRL_RUN: begin
        if (bus.i_trap) begin
          flush     = M_ALL;
          drain_clr = 1'b1;
          state_n   = PCTRL_TRAP;
        end else if (bus.i_lsu_stall) begin
          flush = M_MEMWB;
        end else if (bus.i_mc_start) begin
          flush   = M_MEMWB;
          mc_go   = 1'b1;
          state_n = PCTRL_MCWAIT;
        end else if (bus.i_redirect) begin
          // wrong-path ID instruction makes redirect win over load-use
          en     = M_BACK;
          flush  = M_FRONT;
          pc_en  = 1'b1;
          pc_sel = PC_SEL_REDIR;
        end else if (bus.i_load_use) begin
          en    = M_BACK;
          flush = M_IDEX;
        end else begin
          en    = M_ALL;
          pc_en = 1'b1;
        end
      end
      PCTRL_MCWAIT: begin
        if (bus.i_trap) begin
          mc_kill   = 1'b1;
          flush     = M_ALL;
          drain_clr = 1'b1;
          state_n   = PCTRL_TRAP;
        end else if (bus.i_mc_done) begin
          en      = M_ALL;
          pc_en   = 1'b1;
          state_n = PCTRL_RUN;
        end else begin
          flush = M_MEMWB;
        end
      end
      PCTRL_TRAP: begin
        flush = M_ALL;
        if ((drain == DRAIN_MAX) && !bus.i_lsu_busy) begin
          pc_en   = 1'b1;
          pc_sel  = PC_SEL_TRAP;
          state_n = PCTRL_RUN;
        end
      end
      default: state_n = PCTRL_RUN;
    endcase

    // reset dominates combinationally so no pulse escapes from MCWAIT/TRAP
    if (i_rst) begin
      en        = M_NONE;
      flush     = M_ALL;
      pc_en     = 1'b0;
      pc_sel    = PC_SEL_SEQ;
      mc_go     = 1'b0;
      mc_kill   = 1'b0;
      drain_clr = 1'b1;
      state_n   = PCTRL_RUN;
    end
  end

  assign bus.o_en      = en & ~flush;
  assign bus.o_flush   = flush;
  assign bus.o_pc_en   = pc_en;
  assign bus.o_pc_sel  = pc_sel;
  assign bus.o_mc_go   = mc_go;
  assign bus.o_mc_kill = mc_kill;

  assign stall_inc = !pc_en && (state != PCTRL_TRAP);

  sat_cnt #(
    .W(CNT_W)
  ) u_stall_cnt (
    .i_clk (i_clk),
    .i_clr (i_rst),
    .i_inc (stall_inc),
    .o_cnt (bus.o_stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a cycle-level reference model and
// hand-computed spot checks.
module tb_pipe_ctrl;

  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = 15;

  localparam int M_RUN  = 0;
  localparam int M_MC   = 1;
  localparam int M_TRAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(
    .FLUSH_CYC(FLUSH_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  int mode  = M_RUN;
  int age   = 0;
  int m_cnt = 0;

  always @(negedge clk) begin : mdl
    logic [3:0] xe, xf;
    logic       xp, xg, xk;
    logic [1:0] xs;
    int         nmode;
    logic [18:0] got, exp_v;
    xe = 4'b0000; xf = 4'b0000; xp = 1'b0; xs = 2'b00; xg = 1'b0; xk = 1'b0;
    nmode = mode;
    if (rst) begin
      xf = 4'b1111;
      nmode = M_RUN;
    end else if (mode == M_RUN) begin
      if (bus.i_trap) begin
        xf = 4'b1111; nmode = M_TRAP;
      end else if (bus.i_lsu_stall) begin
        xf = 4'b1000;
      end else if (bus.i_mc_start) begin
        xf = 4'b1000; xg = 1'b1; nmode = M_MC;
      end else if (bus.i_redirect) begin
        xe = 4'b1100; xf = 4'b0011; xp = 1'b1; xs = 2'b01;
      end else if (bus.i_load_use) begin
        xe = 4'b1100; xf = 4'b0010;
      end else begin
        xe = 4'b1111; xp = 1'b1;
      end
    end else if (mode == M_MC) begin
      if (bus.i_trap) begin
        xk = 1'b1; xf = 4'b1111; nmode = M_TRAP;
      end else if (bus.i_mc_done) begin
        xe = 4'b1111; xp = 1'b1; nmode = M_RUN;
      end else begin
        xf = 4'b1000;
      end
    end else begin
      xf = 4'b1111;
      if (age == FLUSH_CYC && !bus.i_lsu_busy) begin
        xp = 1'b1; xs = 2'b10; nmode = M_RUN;
      end
    end

    got   = {bus.o_en, bus.o_flush, bus.o_pc_en, bus.o_pc_sel,
             bus.o_mc_go, bus.o_mc_kill, bus.o_stall_cnt};
    exp_v = {xe, xf, xp, xs, xg, xk, 4'(m_cnt)};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL model t=%0t en/flush/pcen/sel/go/kill/cnt got=%b required=%b",
               $time, got, exp_v);
    end

    if (rst) m_cnt = 0;
    else if (!xp && mode != M_TRAP && m_cnt < CNT_MAX) m_cnt++;

    if (rst) age = 0;
    else if (nmode == M_TRAP && mode != M_TRAP) age = 0;
    else if (mode == M_TRAP && age < FLUSH_CYC) age++;

    mode = nmode;
  end

  task automatic drive(input logic r, input logic tr, input logic ls, input logic mcs,
                       input logic rd, input logic lu, input logic mcd, input logic busy);
    @(posedge clk);
    #1;
    rst             = r;
    bus.i_trap      = tr;
    bus.i_lsu_stall = ls;
    bus.i_mc_start  = mcs;
    bus.i_redirect  = rd;
    bus.i_load_use  = lu;
    bus.i_mc_done   = mcd;
    bus.i_lsu_busy  = busy;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lit(input string nm, input logic [3:0] en, input logic [3:0] fl,
                     input logic pcen, input logic [1:0] sel);
    checks++;
    if (bus.o_en !== en || bus.o_flush !== fl || bus.o_pc_en !== pcen || bus.o_pc_sel !== sel) begin
      errors++;
      $display("FAIL %s en=%b flush=%b pc_en=%b sel=%b required en=%b flush=%b pc_en=%b sel=%b",
               nm, bus.o_en, bus.o_flush, bus.o_pc_en, bus.o_pc_sel, en, fl, pcen, sel);
    end
  endtask

  task automatic lit_mc(input string nm, input logic go, input logic kill);
    checks++;
    if (bus.o_mc_go !== go || bus.o_mc_kill !== kill) begin
      errors++;
      $display("FAIL %s go=%b kill=%b required go=%b kill=%b",
               nm, bus.o_mc_go, bus.o_mc_kill, go, kill);
    end
  endtask

  task automatic lit_cnt(input string nm, input int v);
    checks++;
    if (int'(bus.o_stall_cnt) != v) begin
      errors++;
      $display("FAIL %s stall_cnt=%0d required=%0d", nm, bus.o_stall_cnt, v);
    end
  endtask

  initial begin
    bus.i_trap = 1'b0; bus.i_lsu_stall = 1'b0; bus.i_mc_start = 1'b0;
    bus.i_redirect = 1'b0; bus.i_load_use = 1'b0; bus.i_mc_done = 1'b0;
    bus.i_lsu_busy = 1'b0;

    do_reset();
    lit("reset_out", 4'b0000, 4'b1111, 1'b0, 2'b00);
    lit_mc("reset_pulses", 1'b0, 1'b0);
    lit_cnt("reset_cnt", 0);
    idle();
    lit("run_idle", 4'b1111, 4'b0000, 1'b1, 2'b00);

    // load-use
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    lit("load_use", 4'b1100, 4'b0010, 1'b0, 2'b00);
    lit_cnt("load_use_cnt0", 0);
    idle();
    lit("after_load_use", 4'b1111, 4'b0000, 1'b1, 2'b00);
    lit_cnt("load_use_cnt1", 1);

    // redirect beats load-use
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    lit("redir_lu", 4'b1100, 4'b0011, 1'b1, 2'b01);
    idle();
    lit_cnt("redir_cnt_same", 1);

    // multi-cycle op: start cycles 0-5, done at cycle 5
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, (c == 5), 1'b0);
      if (c == 0) lit_mc("mc_go_c0", 1'b1, 1'b0);
      if (c == 3) begin
        lit_mc("mc_go_c3", 1'b0, 1'b0);
        lit("mc_wait_c3", 4'b0000, 4'b1000, 1'b0, 2'b00);
      end
      if (c == 5) begin
        lit("mc_done_c5", 4'b1111, 4'b0000, 1'b1, 2'b00);
        lit_cnt("mc_cnt_c5", 5);
      end
    end
    idle();

    // trap with bus busy through cycle 4
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    lit("trap_c0", 4'b0000, 4'b1111, 1'b0, 2'b00);
    for (int c = 1; c <= 4; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (c == 3) lit("trap_c3_busy", 4'b0000, 4'b1111, 1'b0, 2'b00);
    end
    idle();
    lit("trap_vec", 4'b0000, 4'b1111, 1'b1, 2'b10);
    idle();
    lit("trap_back_run", 4'b1111, 4'b0000, 1'b1, 2'b00);
    lit_cnt("trap_cnt", 1);

    // trap during MCWAIT, then a stray done inside TRAP
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    lit_mc("mc_kill", 1'b0, 1'b1);
    lit("mc_kill_flush", 4'b0000, 4'b1111, 1'b0, 2'b00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    lit_mc("kill_once", 1'b0, 1'b0);
    lit("done_in_trap", 4'b0000, 4'b1111, 1'b0, 2'b00);
    for (int c = 0; c < 4; c++) idle();

    // all hazards at once, then reset mid-TRAP
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    lit("all_hazards", 4'b0000, 4'b1111, 1'b0, 2'b00);
    lit_mc("all_hazards_pulses", 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    lit("rst_mid_trap", 4'b1111, 4'b0000, 1'b1, 2'b00);
    lit_cnt("rst_mid_trap_cnt", 0);

    // saturation of the stall counter
    for (int c = 0; c < 20; c++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    lit_cnt("sat_cnt", 15);
    idle();
    lit_cnt("sat_hold", 15);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the core's pipeline registers. It drives the enable and flush of the four stage-boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It resolves load-use, branch redirect, LSU bus wait, multi-cycle EX ops and traps, with fixed priority. It also keeps a saturating stall-cycle performance counter.

Parameters:
FLUSH_CYC, 2, minimum cycles spent in TRAP before the trap-vector fetch; must be >=1.
CNT_W, 32, width of the stall performance counter.

Ports:
i_clk  in  1  core clock
i_rst  in  1  synchronous reset, active-high
i_load_use  in  1  ID instruction depends on the load currently in EX
i_redirect  in  1  EX resolved a taken branch or jump
i_mc_start  in  1  EX holds a valid multi-cycle op (div/mul); level signal
i_mc_done  in  1  multi-cycle unit result valid; 1-cycle pulse
i_lsu_stall  in  1  MEM access waiting on the bus
i_lsu_busy  in  1  bus transaction outstanding (used for trap drain)
i_trap  in  1  MEM raised an exception or took an interrupt
o_en  out  4  per-boundary load enable; bit0=IF/ID … bit3=MEM/WB
o_flush  out  4  per-boundary bubble insert; the register loads a NOP/zero
o_pc_en  out  1  PC register enable
o_pc_sel  out  2  00 sequential, 01 redirect, 10 trap vector
o_mc_go  out  1  1-cycle start pulse to the multi-cycle unit
o_mc_kill  out  1  1-cycle abort pulse to the multi-cycle unit
o_stall_cnt  out  CNT_W  cycles with o_pc_en=0 outside TRAP; saturates

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - While i_rst=1: o_en=0000, o_flush=1111, o_pc_en=0, o_pc_sel=00, o_mc_go=0, o_mc_kill=0.
  - State resets to RUN; drain counter and o_stall_cnt reset to 0.
- Outputs are combinational from state and inputs. There is zero-cycle latency from hazard inputs to o_en/o_flush.
- Flush rule: o_flush[k]=1 forces o_en[k]=0. The register loads a bubble regardless of o_en.
- States: RUN, MCWAIT, TRAP.
- RUN, decisions in priority order (first match wins):
  1. i_trap:
     - o_flush=1111, o_en=0000, o_pc_en=0.
     - Clear the drain counter; next state TRAP.
  2. i_lsu_stall:
     - o_en=0000, o_flush=1000, o_pc_en=0.
  3. i_mc_start:
     - o_en=0000, o_flush=1000, o_pc_en=0, o_mc_go=1.
     - Next state MCWAIT.
  4. i_redirect:
     - o_flush=0011, o_en=1100, o_pc_en=1, o_pc_sel=01.
     - Redirect beats load-use because the ID instruction is wrong-path.
  5. i_load_use:
     - o_en=1100, o_flush=0010, o_pc_en=0. IF/ID and PC hold.
  6. Otherwise: o_en=1111, o_flush=0000, o_pc_en=1, o_pc_sel=00.
- MCWAIT:
  - i_trap: o_mc_kill=1, o_flush=1111, o_pc_en=0; next state TRAP.
  - else i_mc_done: o_en=1111, o_flush=0000, o_pc_en=1; next state RUN. The other inputs are ignored in this cycle.
  - else: o_en=0000, o_flush=1000, o_pc_en=0. i_mc_start is ignored in MCWAIT, so no second o_mc_go.
- TRAP:
  - Every cycle: o_en=0000, o_flush=1111, o_pc_en=0; the drain counter increments, saturating at FLUSH_CYC.
  - Exit when counter==FLUSH_CYC and i_lsu_busy=0: o_pc_en=1, o_pc_sel=10 for exactly that cycle; next state RUN.
  - i_trap inside TRAP is ignored.
- o_stall_cnt:
  - Increments when o_pc_en=0, state!=TRAP and i_rst=0.
  - Holds at all-ones.
- Reset asserted mid-MCWAIT or mid-TRAP returns to RUN with no pulses issued.
- o_mc_go and o_mc_kill are never high in the same cycle.

Decomposition:
- Add to defines.v:
  - state encodings PCTRL_RUN/MCWAIT/TRAP;
  - PC_SEL_SEQ/REDIR/TRAP;
  - boundary indices B_IFID=0, B_IDEX=1, B_EXMEM=2, B_MEMWB=3.
- One sub-module, sat_cnt, is natural: a CNT_W saturating up-counter with synchronous active-high clear. It implements o_stall_cnt.

Test Plan:
- Load-use: i_load_use=1 for 1 cycle in RUN -> o_en=1100, o_flush=0010, o_pc_en=0, o_stall_cnt 0->1; the next cycle gives o_en=1111.
- Redirect plus load-use in the same cycle -> o_flush=0011, o_en=1100, o_pc_sel=01, o_pc_en=1; the stall counter is unchanged.
- Multi-cycle op:
  - Stimulus: i_mc_start at cycle 0, i_mc_done at cycle 5.
  - o_mc_go is high only at cycle 0.
  - Cycles 0-4: o_en=0000, o_flush=1000.
  - Cycle 5: o_en=1111, state RUN; o_stall_cnt=5.
- Trap with FLUSH_CYC=2 and i_lsu_busy high until cycle 4:
  - Cycle 0: o_flush=1111.
  - Cycles 1-4: TRAP, o_pc_en=0.
  - PC-vector cycle: o_pc_sel=10, o_pc_en=1, the cycle after i_lsu_busy falls.
- Trap during MCWAIT -> o_mc_kill=1 for exactly one cycle, o_flush=1111, and a later i_mc_done is ignored in TRAP.
- Priority and reset:
  - All hazard inputs high in RUN -> trap path taken.
  - i_rst pulsed mid-TRAP -> next cycle in RUN with o_en=1111 and o_stall_cnt=0.
  - Force o_stall_cnt to all-ones (CNT_W=4) -> holds at 15.
